// File: rtl/mdu_iter_if.sv
// Request/result handshake bundle for the iterative multiply/divide unit.
interface mdu_iter_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [2:0]      funct;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;

    modport master (
        output in_valid, op1, op2, funct, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, op1, op2, funct, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiplier and
// restoring divider sharing one 2*XLEN accumulator, XLEN cycles per op.
module mdu_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_iter_if.slave  bus
);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN-1:0]   opb_q;
    logic [2:0]        funct_q;
    logic              neg_q;
    logic              rem_neg_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   out_q;
    logic [XLEN-1:0]   res_d;

    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res;
    logic              div_zero, div_ovf;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] shifted;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        a_signed = (bus.funct == 3'b001) || (bus.funct == 3'b010) ||
                   (bus.funct == 3'b100) || (bus.funct == 3'b110);
        b_signed = (bus.funct == 3'b001) || (bus.funct == 3'b100) ||
                   (bus.funct == 3'b110);
        sa       = a_signed & bus.op1[XLEN-1];
        sb       = b_signed & bus.op2[XLEN-1];
        mag_a    = sa ? (~bus.op1 + 1'b1) : bus.op1;
        mag_b    = sb ? (~bus.op2 + 1'b1) : bus.op2;
        div_zero = bus.funct[2] && (bus.op2 == '0);
        div_ovf  = bus.funct[2] && !bus.funct[0] &&
                   (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2 == '1);
        if (div_zero)
            fast_res = bus.funct[1] ? bus.op1 : '1;
        else
            fast_res = bus.funct[1] ? '0 : bus.op1;
    end

    // Multiply keeps the multiplier in the low half and shifts the sum in from
    // the top; divide keeps {partial remainder, dividend/quotient}. The bit
    // shifted out of the remainder joins the trial subtraction as its MSB.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        shifted  = {acc_q[2*XLEN-2:0], 1'b0};
        trial    = {acc_q[2*XLEN-1], shifted[2*XLEN-1:XLEN]} - {1'b0, opb_q};
        div_next = trial[XLEN] ? shifted
                               : {trial[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
        acc_d    = funct_q[2] ? div_next : mul_next;
        prod     = neg_q ? (~acc_d + 1'b1) : acc_d;
        quo      = neg_q ? (~acc_d[XLEN-1:0] + 1'b1) : acc_d[XLEN-1:0];
        rem      = rem_neg_q ? (~acc_d[2*XLEN-1:XLEN] + 1'b1) : acc_d[2*XLEN-1:XLEN];
        case (funct_q)
            3'b000:                 res_d = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_d = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_d = quo;
            default:                res_d = rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            funct_q     <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        funct_q    <= bus.funct;
                        in_ready_q <= 1'b0;
                        if (div_zero || div_ovf) begin
                            out_q       <= fast_res;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            cnt_q     <= CW'(XLEN);
                            acc_q     <= {{XLEN{1'b0}}, (bus.funct[2] ? mag_a : mag_b)};
                            opb_q     <= bus.funct[2] ? mag_b : mag_a;
                            neg_q     <= sa ^ sb;
                            rem_neg_q <= sa;
                            state_q   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        out_q       <= res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
endmodule
